instr_sequencer: RTL and testbench

- Fetch/decode/control stage directly upstream of the 16x4 register file.
- Holds a small program memory, steps a program counter through it, and decodes each 16-bit word into signals the register file and ALU consume: 12-bit `instruction`, `ALU_Src`, `Reg_Write`, `Reg_Store`, and an ALU operation code.
- Sequences each instruction over four cycles so register reads and write-back land on the register file's clock edges.

---
 rtl/instr_sequencer.sv | 152 +++++++++++++++
 tb/tb_instr_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/control sequencer feeding a 16x4 register file and ALU.
// Each instruction runs FETCH -> DECODE -> EXEC -> WB so register reads land
// on the DECODE exit edge and write-back lands on the WB exit edge.
module instr_sequencer #(
    parameter int PC_W = 4,
    parameter int OP_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [15:0]     prog_data,
    input  logic            run,
    output logic [11:0]     instruction,
    output logic [OP_W-1:0] ALU_op,
    output logic            ALU_Src,
    output logic            Reg_Write,
    output logic            Reg_Store,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_SUB  = 4'h2;
    localparam logic [3:0] OPC_AND  = 4'h3;
    localparam logic [3:0] OPC_OR   = 4'h4;
    localparam logic [3:0] OPC_ADDI = 4'h5;
    localparam logic [3:0] OPC_SUBI = 4'h6;
    localparam logic [3:0] OPC_CMP  = 4'h7;
    localparam logic [3:0] OPC_JMP  = 4'h8;
    localparam logic [3:0] OPC_HALT = 4'hF;

    localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(3'd0);
    localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(3'd1);
    localparam logic [OP_W-1:0] ALU_AND  = OP_W'(3'd2);
    localparam logic [OP_W-1:0] ALU_OR   = OP_W'(3'd3);
    localparam logic [OP_W-1:0] ALU_PASS = OP_W'(3'd4);

    // Opcode -> {ALU_op, ALU_Src, Reg_Store}. Non-ALU opcodes select PASS
    // and never store.
    function automatic logic [OP_W+1:0] decode_ctrl(input logic [3:0] opc);
        logic [OP_W-1:0] op;
        logic            src;
        logic            store;
        op    = ALU_PASS;
        src   = 1'b0;
        store = 1'b0;
        case (opc)
            OPC_ADD:  begin op = ALU_ADD; store = 1'b1; end
            OPC_SUB:  begin op = ALU_SUB; store = 1'b1; end
            OPC_AND:  begin op = ALU_AND; store = 1'b1; end
            OPC_OR:   begin op = ALU_OR;  store = 1'b1; end
            OPC_ADDI: begin op = ALU_ADD; src = 1'b1; store = 1'b1; end
            OPC_SUBI: begin op = ALU_SUB; src = 1'b1; store = 1'b1; end
            OPC_CMP:  begin op = ALU_SUB; end
            default:  begin op = ALU_PASS; src = 1'b0; store = 1'b0; end
        endcase
        return {op, src, store};
    endfunction

    logic [15:0]  mem [0:(1<<PC_W)-1];
    state_t       state_r;
    state_t       state_s;
    logic [3:0]   ir_op_r;       // opcode half of the IR; field half is `instruction`
    logic [15:0]  fetch_word_s;

    assign fetch_word_s = mem[pc];

    // Program memory load port, only open while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (state_r == S_IDLE && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:   begin
                if (run) state_s = S_FETCH;
                else     state_s = S_IDLE;
            end
            S_FETCH:  state_s = S_DECODE;
            S_DECODE: begin
                if (ir_op_r == OPC_JMP)       state_s = S_FETCH;
                else if (ir_op_r == OPC_HALT) state_s = S_HALT;
                else                          state_s = S_EXEC;
            end
            S_EXEC:   state_s = S_WB;
            S_WB:     begin
                if (run) state_s = S_FETCH;
                else     state_s = S_IDLE;
            end
            S_HALT:   begin
                if (run) state_s = S_HALT;
                else     state_s = S_IDLE;
            end
            default:  state_s = S_IDLE;
        endcase
    end

    // State register, IR, PC and registered control outputs. The fetched word
    // is decoded onto the outputs at the FETCH exit edge so the register file
    // sees stable fields for the whole DECODE cycle and they hold through WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            ir_op_r     <= 4'h0;
            instruction <= 12'h000;
            ALU_op      <= {OP_W{1'b0}};
            ALU_Src     <= 1'b0;
            Reg_Store   <= 1'b0;
            Reg_Write   <= 1'b0;
            pc          <= {PC_W{1'b0}};
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_r   <= state_s;
            Reg_Write <= (state_s == S_WB);
            busy      <= (state_s == S_FETCH) || (state_s == S_DECODE) ||
                         (state_s == S_EXEC)  || (state_s == S_WB);
            halted    <= (state_s == S_HALT);
            case (state_r)
                S_FETCH: begin
                    ir_op_r     <= fetch_word_s[15:12];
                    instruction <= fetch_word_s[11:0];
                    {ALU_op, ALU_Src, Reg_Store} <= decode_ctrl(fetch_word_s[15:12]);
                end
                S_DECODE: begin
                    if (ir_op_r == OPC_JMP) pc <= instruction[PC_W-1:0];
                end
                S_WB:     pc <= pc + PC_W'(1'b1);
                S_HALT: begin
                    if (!run) pc <= {PC_W{1'b0}};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a table-driven program checked by
// a write-back scoreboard, plus cycle-exact hand sequences for corner cases.
module tb_instr_sequencer;
    localparam int PC_W = 4;
    localparam int OP_W = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            prog_we;
    logic [PC_W-1:0] prog_addr;
    logic [15:0]     prog_data;
    logic            run;
    logic [11:0]     instruction;
    logic [OP_W-1:0] ALU_op;
    logic            ALU_Src;
    logic            Reg_Write;
    logic            Reg_Store;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;

    instr_sequencer #(.PC_W(PC_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .run(run), .instruction(instruction),
        .ALU_op(ALU_op), .ALU_Src(ALU_Src), .Reg_Write(Reg_Write),
        .Reg_Store(Reg_Store), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [11:0] instr;
        logic [2:0]  op;
        logic        src;
        logic        store;
        logic        chk_op;
    } vec_t;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [11:0]     instr;
        logic [2:0]      op;
        logic            src;
        logic            store;
        logic            chk_op;
    } exp_t;

    int   checks = 0;
    int   passes = 0;
    bit   sb_en  = 1'b0;
    exp_t sbq[$];
    exp_t sb_e;
    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; prog_we = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [PC_W-1:0] a, input logic [15:0] d);
        prog_addr = a; prog_data = d; prog_we = 1'b1;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_instr"}, 32'(instruction), 32'h0);
        check({tag, "_op"},    32'(ALU_op),      32'h0);
        check({tag, "_src"},   32'(ALU_Src),     32'h0);
        check({tag, "_wr"},    32'(Reg_Write),   32'h0);
        check({tag, "_store"}, 32'(Reg_Store),   32'h0);
        check({tag, "_pc"},    32'(pc),          32'h0);
        check({tag, "_busy"},  32'(busy),        32'h0);
        check({tag, "_halt"},  32'(halted),      32'h0);
    endtask

    // Scoreboard: every Reg_Write pulse must match the next expected record.
    always @(negedge clk) begin
        if (sb_en && Reg_Write) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected_wb: write-back at pc=%0d, none expected", pc);
            end else begin
                sb_e = sbq.pop_front();
                check("sb_pc",    32'(pc),          32'(sb_e.pc));
                check("sb_instr", 32'(instruction), 32'(sb_e.instr));
                check("sb_src",   32'(ALU_Src),     32'(sb_e.src));
                check("sb_store", 32'(Reg_Store),   32'(sb_e.store));
                if (sb_e.chk_op) check("sb_op", 32'(ALU_op), 32'(sb_e.op));
            end
        end
    end

    initial begin
        int   pm;
        int   pulses;
        int   bad_pat;
        int   not_busy;
        logic [PC_W-1:0] pc63;
        logic [PC_W-1:0] pc64;
        exp_t t;

        vt[0]  = '{16'h5305, 12'h305, 3'd0, 1'b1, 1'b1, 1'b1}; // ADDI
        vt[1]  = '{16'h7120, 12'h120, 3'd1, 1'b0, 1'b0, 1'b1}; // CMP
        vt[2]  = '{16'h1abc, 12'habc, 3'd0, 1'b0, 1'b1, 1'b1}; // ADD
        vt[3]  = '{16'h2123, 12'h123, 3'd1, 1'b0, 1'b1, 1'b1}; // SUB
        vt[4]  = '{16'h3456, 12'h456, 3'd2, 1'b0, 1'b1, 1'b1}; // AND
        vt[5]  = '{16'h4789, 12'h789, 3'd3, 1'b0, 1'b1, 1'b1}; // OR
        vt[6]  = '{16'h6a1b, 12'ha1b, 3'd1, 1'b1, 1'b1, 1'b1}; // SUBI
        vt[7]  = '{16'h0000, 12'h000, 3'd0, 1'b0, 1'b0, 1'b0}; // NOP
        vt[8]  = '{16'h9fff, 12'hfff, 3'd0, 1'b0, 1'b0, 1'b0}; // undefined -> NOP
        vt[9]  = '{16'h800b, 12'h00b, 3'd0, 1'b0, 1'b0, 1'b0}; // JMP 11
        vt[10] = '{16'h1111, 12'h111, 3'd0, 1'b0, 1'b1, 1'b1}; // skipped
        vt[11] = '{16'hf000, 12'h000, 3'd0, 1'b0, 1'b0, 1'b0}; // HALT

        prog_addr = '0; prog_data = 16'h0000;

        // Reset state
        rst = 1'b1; run = 1'b0; prog_we = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Table program with scoreboard
        for (int i = 0; i < 12; i++) load(PC_W'(i), vt[i].word);
        pm = 0;
        for (int n = 0; n < 40; n++) begin
            if (vt[pm].word[15:12] == 4'hF) break;
            if (vt[pm].word[15:12] == 4'h8) begin
                pm = int'(vt[pm].word[3:0]);
            end else begin
                t.pc = PC_W'(pm); t.instr = vt[pm].instr; t.op = vt[pm].op;
                t.src = vt[pm].src; t.store = vt[pm].store; t.chk_op = vt[pm].chk_op;
                sbq.push_back(t);
                pm = (pm + 1) % 16;
            end
        end
        sb_en = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 300 && !halted; k++) tick();
        check("table_halted", 32'(halted), 32'h1);
        check("table_sb_drained", 32'(sbq.size()), 32'h0);
        check("table_halt_pc", 32'(pc), 32'd11);
        check("table_halt_busy", 32'(busy), 32'h0);
        sb_en = 1'b0;
        run = 1'b0;
        tick();
        check("halt_exit_pc", 32'(pc), 32'h0);
        check("halt_exit_halted", 32'(halted), 32'h0);

        // ADDI / CMP / JMP timing, then run dropped in DECODE
        do_reset();
        load(4'd0, 16'h5305); load(4'd1, 16'h7120); load(4'd2, 16'h8000);
        run = 1'b1;
        tick(); check("a_fetch_busy", 32'(busy), 32'h1);
        tick(); check("a_dec_instr", 32'(instruction), 32'h305);
        check("a_dec_src", 32'(ALU_Src), 32'h1);
        check("a_dec_op", 32'(ALU_op), 32'h0);
        tick(); check("a_exec_wr", 32'(Reg_Write), 32'h0);
        tick(); check("a_wb_wr", 32'(Reg_Write), 32'h1);
        check("a_wb_store", 32'(Reg_Store), 32'h1);
        check("a_wb_pc", 32'(pc), 32'h0);
        tick(); check("a_pc_inc", 32'(pc), 32'h1);
        check("a_wr_drop", 32'(Reg_Write), 32'h0);
        tick(); check("cmp_op", 32'(ALU_op), 32'h1);
        tick(); tick();
        check("cmp_wr", 32'(Reg_Write), 32'h1);
        check("cmp_store", 32'(Reg_Store), 32'h0);
        tick(); check("jmp_fetch_pc", 32'(pc), 32'h2);
        tick(); check("jmp_dec_wr", 32'(Reg_Write), 32'h0);
        tick(); check("jmp_target_pc", 32'(pc), 32'h0);
        check("jmp_no_wr", 32'(Reg_Write), 32'h0);
        tick(); check("loop_instr", 32'(instruction), 32'h305);
        run = 1'b0;
        tick(); tick();
        check("pause_wb_wr", 32'(Reg_Write), 32'h1);
        tick();
        check("pause_busy", 32'(busy), 32'h0);
        check("pause_pc", 32'(pc), 32'h1);

        // prog_we while busy is ignored; rst in EXEC clears everything
        run = 1'b1;
        tick();
        prog_addr = 4'd1; prog_data = 16'h4fff; prog_we = 1'b1;
        run = 1'b0;
        tick(); tick(); tick(); tick();
        prog_we = 1'b0;
        check("busy_we_idle_pc", 32'(pc), 32'h2);
        do_reset();
        run = 1'b1;
        tick(); tick(); tick(); tick(); tick(); tick();
        check("busy_we_mem_instr", 32'(instruction), 32'h120);
        check("busy_we_mem_op", 32'(ALU_op), 32'h1);
        tick();
        #2; rst = 1'b1; #1;
        check_all_zero("rst_exec");
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (Reg_Write) pulses++;
        end
        check("rst_exec_no_wr", 32'(pulses), 32'h0);
        run = 1'b0; rst = 1'b0;
        tick();
        check("rst_exec_idle", 32'(busy), 32'h0);

        // 16 NOPs: pc wrap, Reg_Write every 4th cycle, busy held
        do_reset();
        for (int a = 0; a < 16; a++) load(PC_W'(a), 16'h0000);
        run = 1'b1;
        tick();
        pulses = 0; bad_pat = 0; not_busy = 0; pc63 = '0; pc64 = '1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (Reg_Write !== ((k % 4) == 3)) bad_pat++;
            if (Reg_Write) pulses++;
            if (busy !== 1'b1) not_busy++;
            if (k == 63) pc63 = pc;
            if (k == 64) pc64 = pc;
        end
        check("nop_pulses", 32'(pulses), 32'd16);
        check("nop_pattern", 32'(bad_pat), 32'h0);
        check("nop_busy", 32'(not_busy), 32'h0);
        check("nop_pc15", 32'(pc63), 32'd15);
        check("nop_wrap", 32'(pc64), 32'h0);
        run = 1'b0;
        tick(); tick(); tick(); tick();
        check("nop_stop_busy", 32'(busy), 32'h0);
        check("nop_stop_pc", 32'(pc), 32'h1);

        // HALT at address 0, leave via run=0, restart with a same-cycle load
        do_reset();
        load(4'd0, 16'hF000);
        run = 1'b1;
        tick(); tick(); tick();
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_busy", 32'(busy), 32'h0);
        tick(); tick(); tick();
        check("halt_hold", 32'(halted), 32'h1);
        check("halt_pc_frozen", 32'(pc), 32'h0);
        run = 1'b0;
        tick();
        check("halt_to_idle", 32'(halted), 32'h0);
        check("halt_idle_pc", 32'(pc), 32'h0);
        prog_addr = 4'd0; prog_data = 16'h2abc; prog_we = 1'b1; run = 1'b1;
        tick();
        prog_we = 1'b0;
        tick();
        check("restart_instr", 32'(instruction), 32'habc);
        check("restart_op", 32'(ALU_op), 32'h1);
        check("restart_pc", 32'(pc), 32'h0);
        check("restart_busy", 32'(busy), 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
